// File: rtl/load_extend_ctrl_if.sv
// Request, memory-read and response signals of the sub-word load controller.
// The master modport is the controller side; slave is the pipeline/memory side.
interface load_extend_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              stall;

  modport master (
    input  req_valid, req_addr, req_size, req_signed, mem_rdata, mem_rvalid, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err, stall
  );

  modport slave (
    output req_valid, req_addr, req_size, req_signed, mem_rdata, mem_rvalid, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err, stall
  );
endinterface

// File: rtl/load_extend_ctrl.sv
// MEM-stage sub-word load sequencer: one aligned word read per request, lane select,
// sign/zero extension, and a held valid/ready response; stalls the pipeline while busy.
module load_extend_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst_n,
  load_extend_ctrl_if.master  bus
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              req_bad;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ext_data;

  // Misaligned half/word or the reserved size encoding never touches memory.
  always_comb begin
    req_bad = 1'b0;
    unique case (bus.req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = bus.req_addr[0];
      2'b10:   req_bad = |bus.req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    lane_b = 8'h00;
    unique case (addr_q[1:0])
      2'b00: lane_b = bus.mem_rdata[7:0];
      2'b01: lane_b = bus.mem_rdata[15:8];
      2'b10: lane_b = bus.mem_rdata[23:16];
      2'b11: lane_b = bus.mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    unique case (size_q)
      2'b00:   ext_data = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   ext_data = {{16{signed_q & lane_h[15]}}, lane_h};
      default: ext_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          if (req_bad) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0;
            state_d    = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = 8'h00;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 8'h01;
        // Data arriving on the last allowed cycle still beats the timeout.
        if (bus.mem_rvalid) begin
          rsp_data_d = ext_data;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else if (cnt_q == TimeoutLast) begin
          rsp_data_d = 32'h0;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'h00;
      addr_q     <= '0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // req_ready is gated by rst_n so every output reads 0 while reset is held.
  assign bus.req_ready = rst_n & (state_q == StIdle);
  assign bus.mem_rd_en = (state_q == StIssue);
  assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.stall     = (state_q != StIdle);

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Directed, table-driven bench for load_extend_ctrl (TIMEOUT=4), plus hand-written
// backpressure, stray-rvalid and reset-mid-load sequences.
module tb_load_extend_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_extend_ctrl_if #(.ADDR_W(32)) bus ();

  load_extend_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rdata;
    logic        give;     // memory answers in the first WAIT cycle
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_rd;   // number of mem_rd_en cycles
    int          exp_lat;  // negedges after accept until rsp_valid
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, " stall"},     32'(bus.stall),     32'd0);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " mem_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
    check({tag, " rsp_data"},  bus.rsp_data,       32'd0);
    check({tag, " rsp_err"},   32'(bus.rsp_err),   32'd0);
    check({tag, " mem_addr"},  bus.mem_addr,       32'd0);
  endtask

  // Entered and left on a negedge. hold = cycles of rsp_ready low while responding.
  task automatic run_vec(input vec_t v, input int idx, input int hold);
    int          cyc;
    int          rd;
    int          iss;
    bit          got;
    logic [31:0] held;
    string       tag;
    tag = $sformatf("v%0d", idx);
    bus.req_valid  = 1'b1;
    bus.req_addr   = v.addr;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 0;
    rd  = 0;
    iss = -10;
    got = 1'b0;
    while (!got && cyc < 20) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
      end else begin
        if (bus.mem_rd_en) begin
          rd++;
          iss = cyc;
          check({tag, " mem_addr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
        end
        bus.mem_rvalid = v.give && (cyc == iss + 1);
        bus.mem_rdata  = v.give ? v.rdata : 32'hDEAD_BEEF;
        @(negedge clk);
        cyc++;
      end
    end
    bus.mem_rvalid = 1'b0;
    check({tag, " got rsp"}, 32'(got), 32'd1);
    check({tag, " latency"}, cyc, v.exp_lat);
    check({tag, " rd count"}, rd, v.exp_rd);
    check({tag, " rsp_data"}, bus.rsp_data, v.exp_data);
    check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    held = bus.rsp_data;
    for (int k = 0; k < hold; k++) begin
      // Stray read data while the response waits must not disturb it.
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = ~v.rdata;
      @(negedge clk);
      check({tag, " bp rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, " bp rsp_data"}, bus.rsp_data, held);
      check({tag, " bp stall"}, 32'(bus.stall), 32'd1);
      check({tag, " bp req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.mem_rvalid = 1'b0;
    // Handshake with a new request already pending: it must not be taken this edge.
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check({tag, " post stall"}, 32'(bus.stall), 32'd0);
    check({tag, " post req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " post rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1003, 2'b00, 1'b1, 32'h80FF_7F01, 1'b1, 32'hFFFF_FF80, 1'b0, 1, 2};
    vecs[1]  = '{32'h0000_1003, 2'b00, 1'b0, 32'h80FF_7F01, 1'b1, 32'h0000_0080, 1'b0, 1, 2};
    vecs[2]  = '{32'h0000_2002, 2'b01, 1'b1, 32'h8001_1234, 1'b1, 32'hFFFF_8001, 1'b0, 1, 2};
    vecs[3]  = '{32'h0000_2000, 2'b01, 1'b1, 32'h8001_1234, 1'b1, 32'h0000_1234, 1'b0, 1, 2};
    vecs[4]  = '{32'h0000_1001, 2'b00, 1'b1, 32'h80FF_7F01, 1'b1, 32'h0000_007F, 1'b0, 1, 2};
    vecs[5]  = '{32'h0000_1002, 2'b00, 1'b1, 32'h80FF_7F01, 1'b1, 32'hFFFF_FFFF, 1'b0, 1, 2};
    vecs[6]  = '{32'h0000_1000, 2'b00, 1'b0, 32'h80FF_7F01, 1'b1, 32'h0000_0001, 1'b0, 1, 2};
    vecs[7]  = '{32'h0000_3000, 2'b10, 1'b1, 32'h80FF_7F01, 1'b1, 32'h80FF_7F01, 1'b0, 1, 2};
    vecs[8]  = '{32'h0000_2001, 2'b01, 1'b1, 32'h8001_1234, 1'b1, 32'h0000_0000, 1'b1, 0, 0};
    vecs[9]  = '{32'h0000_3002, 2'b10, 1'b0, 32'h8001_1234, 1'b1, 32'h0000_0000, 1'b1, 0, 0};
    vecs[10] = '{32'h0000_4000, 2'b11, 1'b0, 32'h8001_1234, 1'b1, 32'h0000_0000, 1'b1, 0, 0};
    vecs[11] = '{32'h0000_5000, 2'b10, 1'b0, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 1, 5};
    vecs[12] = '{32'h0000_2002, 2'b01, 1'b0, 32'h8001_1234, 1'b1, 32'h0000_8001, 1'b0, 1, 2};

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.mem_rvalid = 1'b0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle req_ready", 32'(bus.req_ready), 32'd1);
    check("idle stall", 32'(bus.stall), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], i, (i == 0) ? 5 : ((i == 11) ? 2 : 0));
    end

    // rvalid while idle is ignored.
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("idle rvalid stall", 32'(bus.stall), 32'd0);
    check("idle rvalid rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset while waiting for memory.
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0000_1003;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst issue rd_en", 32'(bus.mem_rd_en), 32'd1);
    @(negedge clk);
    check("rst wait stall", 32'(bus.stall), 32'd1);
    check("rst wait rd_en", 32'(bus.mem_rd_en), 32'd0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h80FF_7F01;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("late rvalid rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("late rvalid stall", 32'(bus.stall), 32'd0);
      @(negedge clk);
    end
    run_vec(vecs[0], 100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
